// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a valid/ready request channel and a valid/ready
// response channel; one outstanding access, fixed access latency.
module data_mem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h10010000,
   parameter int          LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int                IDX_W    = $clog2(DEPTH_WORDS);
   localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [32:0]      SPAN     = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             err_q;
   logic [31:0]      data_q;
   logic [31:0]      mem [DEPTH_WORDS];

   logic [31:0]      offset;
   logic             addr_err;
   logic [IDX_W-1:0] index;
   logic             accept;

   // Offset wraps modulo 2^32, so addresses below the base land far out of range.
   assign offset   = req_addr - BASE_ADDR;
   assign addr_err = (req_addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
   assign index    = offset[IDX_W+1:2];
   assign accept   = req_valid && (state == IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) err_q <= addr_err;
      end
   end

   // Storage and captured load data carry no reset; a committed store survives reset.
   always_ff @(posedge clock) begin
      if (accept && reset_n) begin
         if (req_write && !addr_err) mem[index] <= req_wdata;
         data_q <= (!req_write && !addr_err) ? mem[index] : 32'h0;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      resp_error = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (LATENCY == 1) begin
                  state_n = RESP;
               end else begin
                  state_n = WAIT;
                  cnt_n   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_n = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = data_q;
            resp_error = err_q;
            if (resp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (LATENCY 2, 1, 4) share
// clock and reset; expected responses flow through a scoreboard queue.
module tb_data_mem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [2:0]  req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
   logic [31:0] req_addr [3];
   logic [31:0] req_wdata [3];
   logic [31:0] resp_rdata [3];

   exp_t sb [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_responder #(
         .DEPTH_WORDS(1024),
         .BASE_ADDR  (32'h10010000),
         .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
      ) dut (
         .clock     (clock),
         .reset_n   (reset_n),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .resp_valid(resp_valid[g]),
         .resp_ready(resp_ready[g]),
         .resp_rdata(resp_rdata[g]),
         .resp_error(resp_error[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request and hold it until accepted; leaves time just after the acceptance edge.
   task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
      int t;
      exp_t e;
      @(negedge clock);
      req_valid[d] = 1'b1;
      req_write[d] = w;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      t = 0;
      while (!req_ready[d] && t < 50) begin
         @(negedge clock);
         t++;
      end
      check("accept_timeout", 32'(t < 50), 32'd1);
      e.rdata = er;
      e.err   = ee;
      sb.push_back(e);
      @(posedge clock);
      #1;
      req_valid[d] = 1'b0;
   endtask

   // Wait for the response, check latency and stability, then handshake.
   task automatic collect(input int d, input int exp_lat, input int hold);
      int   n;
      exp_t e;
      n = 0;
      do begin
         @(negedge clock);
         n++;
         if (!resp_valid[d]) check("req_ready_wait", 32'(req_ready[d]), 32'd0);
      end while (!resp_valid[d] && n < 50);
      check("latency", 32'(n), 32'(exp_lat));
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
      else begin
         e.rdata = 32'h0;
         e.err   = 1'b0;
      end
      check("resp_rdata", resp_rdata[d], e.rdata);
      check("resp_error", 32'(resp_error[d]), 32'(e.err));
      check("req_ready_resp", 32'(req_ready[d]), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         check("hold_valid", 32'(resp_valid[d]), 32'd1);
         check("hold_rdata", resp_rdata[d], e.rdata);
         check("hold_error", 32'(resp_error[d]), 32'(e.err));
         check("hold_req_ready", 32'(req_ready[d]), 32'd0);
      end
      req_valid[d]  = 1'b0;
      resp_ready[d] = 1'b1;
      @(posedge clock);
      #1;
      resp_ready[d] = 1'b0;
      check("post_valid", 32'(resp_valid[d]), 32'd0);
      check("post_rdata", resp_rdata[d], 32'h0);
      check("post_error", 32'(resp_error[d]), 32'd0);
      check("post_req_ready", 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid  = '0;
      req_write  = '0;
      resp_ready = '0;
      for (int i = 0; i < 3; i++) begin
         req_addr[i]  = 32'h0;
         req_wdata[i] = 32'h0;
      end
      reset_n = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) begin
         check("rst_req_ready", 32'(req_ready[i]), 32'd1);
         check("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
         check("rst_resp_rdata", resp_rdata[i], 32'h0);
         check("rst_resp_error", 32'(resp_error[i]), 32'd0);
      end
      @(negedge clock);
      reset_n = 1'b1;

      // Basic store then load
      issue(0, 1'b1, 32'h10010004, 32'hDEADBEEF, 32'h0, 1'b0);
      collect(0, 2, 0);
      issue(0, 1'b0, 32'h10010004, 32'h0, 32'hDEADBEEF, 1'b0);
      collect(0, 2, 0);

      // Misaligned, one past end, below base
      issue(0, 1'b0, 32'h10010002, 32'h0, 32'h0, 1'b1);
      collect(0, 2, 0);
      issue(0, 1'b0, 32'h10011000, 32'h0, 32'h0, 1'b1);
      collect(0, 2, 0);
      issue(0, 1'b0, 32'h1000FFFC, 32'h0, 32'h0, 1'b1);
      collect(0, 2, 0);

      // Out-of-range store must not wrap onto word 0; last word is in range
      issue(0, 1'b1, 32'h10010000, 32'hA5A5A5A5, 32'h0, 1'b0);
      collect(0, 2, 0);
      issue(0, 1'b1, 32'h10011000, 32'hFFFFFFFF, 32'h0, 1'b1);
      collect(0, 2, 0);
      issue(0, 1'b0, 32'h10010000, 32'h0, 32'hA5A5A5A5, 1'b0);
      collect(0, 2, 0);
      issue(0, 1'b1, 32'h10010FFC, 32'hC0FFEE01, 32'h0, 1'b0);
      collect(0, 2, 0);
      issue(0, 1'b0, 32'h10010FFC, 32'h0, 32'hC0FFEE01, 1'b0);
      collect(0, 2, 0);

      // Back-pressure: response held for 5 cycles
      issue(0, 1'b0, 32'h10010004, 32'h0, 32'hDEADBEEF, 1'b0);
      collect(0, 2, 5);

      // Request inputs changed and valid held high after acceptance
      issue(0, 1'b1, 32'h10010014, 32'h0BADF00D, 32'h0, 1'b0);
      collect(0, 2, 0);
      issue(0, 1'b1, 32'h10010010, 32'h11112222, 32'h0, 1'b0);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h10010014;
      req_wdata[0] = 32'h33334444;
      collect(0, 2, 2);
      repeat (3) begin
         @(negedge clock);
         check("no_extra_txn", 32'(resp_valid[0]), 32'd0);
      end
      issue(0, 1'b0, 32'h10010010, 32'h0, 32'h11112222, 1'b0);
      collect(0, 2, 0);
      issue(0, 1'b0, 32'h10010014, 32'h0, 32'h0BADF00D, 1'b0);
      collect(0, 2, 0);

      // Reset during WAIT after a store
      issue(0, 1'b1, 32'h10010008, 32'h12345678, 32'h0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_wait_valid", 32'(resp_valid[0]), 32'd0);
      check("abort_wait_ready", 32'(req_ready[0]), 32'd1);
      sb.delete();
      @(negedge clock);
      reset_n = 1'b1;
      issue(0, 1'b0, 32'h10010008, 32'h0, 32'h12345678, 1'b0);
      collect(0, 2, 0);

      // Reset during RESP drops the response asynchronously
      issue(0, 1'b0, 32'h10010008, 32'h0, 32'h12345678, 1'b0);
      @(negedge clock);
      @(negedge clock);
      check("pre_abort_valid", 32'(resp_valid[0]), 32'd1);
      reset_n = 1'b0;
      #1;
      check("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
      check("abort_resp_rdata", resp_rdata[0], 32'h0);
      check("abort_resp_ready", 32'(req_ready[0]), 32'd1);
      sb.delete();
      @(negedge clock);
      reset_n = 1'b1;

      // LATENCY=1 and LATENCY=4 instances
      issue(1, 1'b1, 32'h10010020, 32'h5555AAAA, 32'h0, 1'b0);
      collect(1, 1, 0);
      issue(1, 1'b0, 32'h10010020, 32'h0, 32'h5555AAAA, 1'b0);
      collect(1, 1, 1);
      issue(2, 1'b1, 32'h10010020, 32'h7777EEEE, 32'h0, 1'b0);
      collect(2, 4, 0);
      issue(2, 1'b0, 32'h10010020, 32'h0, 32'h7777EEEE, 1'b0);
      collect(2, 4, 0);
      issue(2, 1'b0, 32'h10010021, 32'h0, 32'h0, 1'b1);
      collect(2, 4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
